// File: rtl/stream_intf_pkg.sv
// Shared types and constants for the output-stream scheduler slice.
// Optional feature macro used by this slice: PEA_DMA_SCHED_TIMEOUT_EN.
package stream_intf_pkg;

    localparam int unsigned N_PEA_DOUT_PER_OUT_STREAM = 4;
    localparam int unsigned N_DMA_CH_PER_OUT_STREAM   = 2;

    localparam int unsigned SCHED_SEQ_LEN     = 4;
    localparam int unsigned SCHED_XFER_W      = 16;
    localparam int unsigned SCHED_TIMEOUT_CYC = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/pea_dma_sched_ch.sv
// One DMA channel of the scheduler: FSM, sequence pointer, transfer counter.
// Optional stall timeout when PEA_DMA_SCHED_TIMEOUT_EN is defined.
module pea_dma_sched_ch
    import stream_intf_pkg::*;
#(
    parameter  int unsigned N_PEA   = N_PEA_DOUT_PER_OUT_STREAM,
    parameter  int unsigned SEQ_LEN = SCHED_SEQ_LEN,
    parameter  int unsigned XFER_W  = SCHED_XFER_W,
    localparam int unsigned PW      = $clog2(N_PEA),
    localparam int unsigned LW      = $clog2(SEQ_LEN)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [SEQ_LEN-1:0][PW-1:0] seq_i,
    input  logic [LW-1:0]              seq_last_i,
    input  logic [XFER_W-1:0]          n_xfer_i,
    input  logic                       xfer_i,
    output logic [PW-1:0]              sel_o,
    output logic                       run_o,
    output logic                       done_o,
    output logic                       err_o
);

    sched_state_e               state_q, state_d;
    logic [SEQ_LEN-1:0][PW-1:0] seq_q;
    logic [LW-1:0]              last_q, ptr_q, ptr_nxt;
    logic [XFER_W-1:0]          n_q, cnt_q;
    logic                       load, done_d, step, last_xfer;

    assign run_o     = (state_q == RUN);
    assign step      = run_o && xfer_i;
    assign last_xfer = step && (cnt_q == n_q - 1'b1);
    assign ptr_nxt   = (ptr_q == last_q) ? '0 : ptr_q + 1'b1;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, config load strobe and done request.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (n_xfer_i != '0) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Config latch, pointer/counter advance, registered selector and done.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq_q  <= '0;
            last_q <= '0;
            n_q    <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            sel_o  <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= done_d;
            if (load) begin
                seq_q  <= seq_i;
                last_q <= seq_last_i;
                n_q    <= n_xfer_i;
                ptr_q  <= '0;
                cnt_q  <= '0;
                sel_o  <= seq_i[0];
            end else if (step) begin
                ptr_q <= ptr_nxt;
                cnt_q <= cnt_q + 1'b1;
                // The final word leaves the selector on the entry it used.
                if (!last_xfer) sel_o <= seq_q[ptr_nxt];
            end
        end
    end

`ifdef PEA_DMA_SCHED_TIMEOUT_EN
    logic [15:0] stall_q;

    // Stall counter over RUN cycles without a transfer; sticky error flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
            err_o   <= 1'b0;
        end else if (load) begin
            stall_q <= '0;
            err_o   <= 1'b0;
        end else if (run_o) begin
            if (xfer_i) begin
                stall_q <= '0;
            end else begin
                if (stall_q != '1) stall_q <= stall_q + 1'b1;
                if (stall_q == 16'(SCHED_TIMEOUT_CYC - 1)) err_o <= 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/pea_dma_xbar_sched.sv
// PEA->DMA output crossbar scheduler for one output stream.
// Per-channel sequencing lives in pea_dma_sched_ch; fixed-priority conflict
// resolution and PEA acknowledge live here.
// Optional stall timeout when PEA_DMA_SCHED_TIMEOUT_EN is defined.
module pea_dma_xbar_sched
    import stream_intf_pkg::*;
#(
    parameter  int unsigned N_PEA   = N_PEA_DOUT_PER_OUT_STREAM,
    parameter  int unsigned N_CH    = N_DMA_CH_PER_OUT_STREAM,
    parameter  int unsigned SEQ_LEN = SCHED_SEQ_LEN,
    parameter  int unsigned XFER_W  = SCHED_XFER_W,
    localparam int unsigned PW      = $clog2(N_PEA),
    localparam int unsigned LW      = $clog2(SEQ_LEN)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [N_CH-1:0]                      start_i,
    input  logic [N_CH-1:0][SEQ_LEN-1:0][PW-1:0] seq_i,
    input  logic [N_CH-1:0][LW-1:0]              seq_last_i,
    input  logic [N_CH-1:0][XFER_W-1:0]          n_xfer_i,
    input  logic [N_PEA-1:0]                     valid_pea_i,
    input  logic [N_CH-1:0]                      dma_ch_ready_i,
    output logic [N_CH-1:0][PW-1:0]              sel_o,
    output logic [N_CH-1:0]                      ch_en_o,
    output logic [N_PEA-1:0]                     pea_ack_o,
    output logic [N_CH-1:0]                      done_o,
    output logic [N_CH-1:0]                      err_o
);

    logic [N_CH-1:0] run, cand, xfer;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pea_dma_sched_ch #(
            .N_PEA   (N_PEA),
            .SEQ_LEN (SEQ_LEN),
            .XFER_W  (XFER_W)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .start_i    (start_i[c]),
            .seq_i      (seq_i[c]),
            .seq_last_i (seq_last_i[c]),
            .n_xfer_i   (n_xfer_i[c]),
            .xfer_i     (xfer[c]),
            .sel_o      (sel_o[c]),
            .run_o      (run[c]),
            .done_o     (done_o[c]),
            .err_o      (err_o[c])
        );
    end

    assign ch_en_o = run;

    // Candidates, then lowest-index-wins among channels sharing a selector.
    always_comb begin
        cand = '0;
        xfer = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            cand[c] = run[c] & valid_pea_i[sel_o[c]] & dma_ch_ready_i[c];
        end
        for (int unsigned c = 0; c < N_CH; c++) begin
            xfer[c] = cand[c];
            for (int unsigned d = 0; d < c; d++) begin
                if (cand[d] && (sel_o[d] == sel_o[c])) xfer[c] = 1'b0;
            end
        end
    end

    // Acknowledge each PEA output consumed by a winning channel.
    always_comb begin
        pea_ack_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (xfer[c]) pea_ack_o[sel_o[c]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_pea_dma_xbar_sched.sv
// Scoreboard bench for pea_dma_xbar_sched (N_PEA=4, N_CH=2, SEQ_LEN=4).
// Timeout scenario is included when PEA_DMA_SCHED_TIMEOUT_EN is defined.
module tb_pea_dma_xbar_sched;

    logic                       clk_i = 1'b0;
    logic                       rst_n_i;
    logic [1:0]                 start_i;
    logic [1:0][3:0][1:0]       seq_i;
    logic [1:0][1:0]            seq_last_i;
    logic [1:0][15:0]           n_xfer_i;
    logic [3:0]                 valid_pea_i;
    logic [1:0]                 dma_ch_ready_i;
    logic [1:0][1:0]            sel_o;
    logic [1:0]                 ch_en_o;
    logic [3:0]                 pea_ack_o;
    logic [1:0]                 done_o;
    logic [1:0]                 err_o;

    typedef struct packed {
        logic [1:0][1:0] sel;
        logic [1:0]      en;
        logic [3:0]      ack;
        logic [1:0]      done;
        logic [1:0]      err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pea_dma_xbar_sched #(
        .N_PEA   (4),
        .N_CH    (2),
        .SEQ_LEN (4),
        .XFER_W  (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .seq_i          (seq_i),
        .seq_last_i     (seq_last_i),
        .n_xfer_i       (n_xfer_i),
        .valid_pea_i    (valid_pea_i),
        .dma_ch_ready_i (dma_ch_ready_i),
        .sel_o          (sel_o),
        .ch_en_o        (ch_en_o),
        .pea_ack_o      (pea_ack_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: pops the expected output set for the current cycle.
    always @(negedge clk_i) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sel",  8'(sel_o),     8'(e.sel));
            chk("en",   8'(ch_en_o),   8'(e.en));
            chk("ack",  8'(pea_ack_o), 8'(e.ack));
            chk("done", 8'(done_o),    8'(e.done));
            chk("err",  8'(err_o),     8'(e.err));
        end
    end

    task automatic cfg(input int ch, input logic [1:0] s0, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] s3,
                       input logic [1:0] last, input logic [15:0] n);
        seq_i[ch]      = {s3, s2, s1, s0};
        seq_last_i[ch] = last;
        n_xfer_i[ch]   = n;
    endtask

    // Apply one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input logic [1:0] st, input logic [1:0] rdy, input logic [3:0] vld,
                       input logic [1:0] sel1, input logic [1:0] sel0,
                       input logic [1:0] en, input logic [3:0] ack,
                       input logic [1:0] done, input logic [1:0] err);
        exp_t e;
        start_i        = st;
        dma_ch_ready_i = rdy;
        valid_pea_i    = vld;
        e.sel  = {sel1, sel0};
        e.en   = en;
        e.ack  = ack;
        e.done = done;
        e.err  = err;
        sbq.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    logic [1:0] t1_sel [6];
    logic [1:0] t2_rdy [5];
    logic [1:0] t2_sel [5];

    initial begin
        rst_n_i        = 1'b0;
        start_i        = '0;
        seq_i          = '0;
        seq_last_i     = '0;
        n_xfer_i       = '0;
        valid_pea_i    = '0;
        dma_ch_ready_i = '0;
        @(posedge clk_i);
        #1;

        // Reset state
        cyc(2'b00, 2'b11, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);
        rst_n_i = 1'b1;
        cyc(2'b00, 2'b00, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);

        // Single channel, seq {2,0,3,1}, 6 words; a start while RUN is ignored
        t1_sel = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
        cfg(0, 2, 0, 3, 1, 3, 16'd6);
        cyc(2'b01, 2'b01, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) n_xfer_i[0] = 16'd0;
            cyc((i == 2) ? 2'b01 : 2'b00, 2'b01, 4'hF, 0, t1_sel[i],
                2'b01, 4'(1 << t1_sel[i]), 2'b00, 2'b00);
        end
        cyc(2'b00, 2'b01, 4'hF, 0, 0, 2'b00, 4'h0, 2'b01, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);

        // Backpressure: seq {1,3}, 3 words, ready 1,0,1,0,1
        t2_rdy = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        t2_sel = '{2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
        cfg(0, 1, 3, 0, 0, 1, 16'd3);
        cyc(2'b01, 2'b00, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) begin
            cyc(2'b00, t2_rdy[i], 4'hF, 0, t2_sel[i], 2'b01,
                t2_rdy[i][0] ? 4'(1 << t2_sel[i]) : 4'h0, 2'b00, 2'b00);
        end
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b00, 4'h0, 2'b01, 2'b00);

        // Conflict: both channels start on PEA output 1
        cfg(0, 1, 2, 0, 0, 1, 16'd2);
        cfg(1, 1, 0, 0, 0, 1, 16'd2);
        cyc(2'b11, 2'b11, 4'hF, 0, 1, 2'b00, 4'h0, 2'b00, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 1, 1, 2'b11, 4'b0010, 2'b00, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 1, 2, 2'b11, 4'b0110, 2'b00, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 0, 2, 2'b10, 4'b0001, 2'b01, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 0, 2, 2'b00, 4'h0, 2'b10, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 0, 2, 2'b00, 4'h0, 2'b00, 2'b00);

        // Zero-length start on ch1
        cfg(1, 3, 3, 3, 3, 0, 16'd0);
        cyc(2'b10, 2'b11, 4'hF, 0, 2, 2'b00, 4'h0, 2'b00, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 0, 2, 2'b00, 4'h0, 2'b10, 2'b00);
        cyc(2'b00, 2'b11, 4'hF, 0, 2, 2'b00, 4'h0, 2'b00, 2'b00);

        // Reset after 3 of 8 words, then a 2-word run
        cfg(0, 1, 2, 3, 2, 3, 16'd8);
        cyc(2'b01, 2'b01, 4'hF, 0, 2, 2'b00, 4'h0, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b01, 4'b0010, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 2, 2'b01, 4'b0100, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 3, 2'b01, 4'b1000, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'h0, 0, 2, 2'b01, 4'h0, 2'b00, 2'b00);
        valid_pea_i = 4'hF;
        rst_n_i     = 1'b0;
        #1;
        chk("rst_sel",  8'(sel_o),     8'h00);
        chk("rst_en",   8'(ch_en_o),   8'h00);
        chk("rst_ack",  8'(pea_ack_o), 8'h00);
        chk("rst_done", 8'(done_o),    8'h00);
        chk("rst_err",  8'(err_o),     8'h00);
        @(posedge clk_i);
        #1;
        cyc(2'b00, 2'b01, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);
        rst_n_i = 1'b1;
        cfg(0, 3, 1, 0, 0, 1, 16'd2);
        cyc(2'b01, 2'b01, 4'hF, 0, 0, 2'b00, 4'h0, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 3, 2'b01, 4'b1000, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b01, 4'b0010, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b00, 4'h0, 2'b01, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b00, 4'h0, 2'b00, 2'b00);

`ifdef PEA_DMA_SCHED_TIMEOUT_EN
        // Stall 1024 RUN cycles; err sets, survives completion, clears on start
        cfg(0, 1, 2, 3, 0, 0, 16'd2);
        cyc(2'b01, 2'b01, 4'h0, 0, 1, 2'b00, 4'h0, 2'b00, 2'b00);
        for (int i = 1; i <= 1024; i++) begin
            cyc(2'b00, 2'b01, 4'h0, 0, 1, 2'b01, 4'h0, 2'b00, 2'b00);
        end
        cyc(2'b00, 2'b01, 4'h0, 0, 1, 2'b01, 4'h0, 2'b00, 2'b01);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b01, 4'b0010, 2'b00, 2'b01);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b01, 4'b0010, 2'b00, 2'b01);
        cyc(2'b00, 2'b01, 4'hF, 0, 1, 2'b00, 4'h0, 2'b01, 2'b01);
        cfg(0, 3, 0, 0, 0, 0, 16'd1);
        cyc(2'b01, 2'b01, 4'h0, 0, 1, 2'b00, 4'h0, 2'b00, 2'b01);
        cyc(2'b00, 2'b01, 4'h0, 0, 3, 2'b01, 4'h0, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 3, 2'b01, 4'b1000, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 4'hF, 0, 3, 2'b00, 4'h0, 2'b01, 2'b00);
`endif

        @(posedge clk_i);
        #1;
        chk("sb_drain", 8'(sbq.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
